mod_exp_engine: RTL and testbench
=================================

MOD_EXP_ENGINE -- requirements
Module: mod_exp_engine

Interface
REQ-001 The block SHALL have parameter BITS, default 32, giving the operand/result width; all cycle counts below are for BITS=32.
REQ-002 CLK  input  1  clock; all state SHALL change on posedge CLK only.
REQ-003 RESET  input  1  reset, synchronous, active-high.
REQ-004 START  input  1  one-cycle request to begin a computation on m, e, n.
REQ-005 m  input  BITS  message/base operand, any value; m >= n is allowed.
REQ-006 e  input  BITS  exponent.
REQ-007 n  input  BITS  modulus.
REQ-008 r  output  BITS  result, (m^e) mod n.
REQ-009 done  output  1  result valid; level signal held until the next START or RESET.
REQ-010 busy  output  1  high while a computation is in progress.
REQ-011 err  output  1  high with done when n==0.

Function
REQ-012 On START sampled in IDLE or DONE, the block SHALL latch m, e and n into internal registers, clear done and err, and set busy in the next cycle; later input changes SHALL NOT affect the run.
REQ-013 START while busy=1 SHALL be ignored.
REQ-014 The FSM SHALL have the states IDLE, REDUCE, CHECK, MULT, SQUARE and DONE.
REQ-015 If the latched n==0, the FSM SHALL go from START directly to DONE with r=0, err=1 and done=1 one cycle after START.
REQ-016 In REDUCE, the block SHALL compute base = m mod n as modmul(1, m) and initialise acc = (n==1) ? 0 : 1; REDUCE SHALL last exactly 32 cycles.
REQ-017 modmul(a, b) SHALL be interleaved MSB-first shift-add over 32 cycles, one bit of b per cycle.
REQ-018 Each modmul cycle SHALL do: P = 2P; if P >= n then P -= n; if b[i] then P += a; if P >= n then P -= n.
REQ-019 Intermediate modmul values SHALL be held at BITS+2 bits so that no overflow occurs for any n up to 2^BITS-1.
REQ-020 The exponent SHALL be scanned LSB-first from a shift register esh.
REQ-021 In CHECK (1 cycle): if esh==0, go to DONE; else if esh[0]==1, go to MULT; else go to SQUARE.
REQ-022 MULT SHALL compute acc = modmul(acc, base) in 32 cycles; then, if esh[BITS-1:1]==0, go to DONE, otherwise go to SQUARE.
REQ-023 SQUARE SHALL compute base = modmul(base, base) in 32 cycles, shift esh right by 1, then go to CHECK.
REQ-024 On entry to DONE, the block SHALL set r=acc, done=1 and busy=0; r and done SHALL remain stable until the next START or RESET.
REQ-025 Latency, counted from the START edge to the first cycle with done=1:
- e==0: 34 cycles.
- e!=0 with MSB set bit k: 33 + (k+1) + 32*(popcount(e)+k) cycles.
- n==0: 1 cycle.
REQ-026 done SHALL be held for at least 2 cycles so that a two-stage done synchroniser captures r on the rising edge.
REQ-027 START in DONE SHALL drop done the next cycle and begin a new run, with the same timing as from IDLE.
REQ-028 Results SHALL be exact:
- n==1 SHALL give r=0.
- e==0 with n>1 SHALL give r=1.
- m==0 with e>0 SHALL give r=0.

Reset
REQ-029 RESET SHALL force IDLE with r=0, done=0, busy=0 and err=0, and SHALL clear all internal registers.
REQ-030 RESET SHALL take priority over START in the same cycle.
REQ-031 RESET asserted mid-computation SHALL abort the run with no done pulse; a START issued after RESET is released SHALL run normally.

Verification
REQ-032 m=4, e=13, n=497, START -> r=445, err=0, done rises exactly 33+4+32*(3+3)=229 cycles after START.
REQ-033 m=65, e=17, n=3233 -> r=2790, with latency 33+5+32*(2+4)=230 cycles; then m=2790, e=2753, n=3233 -> r=65.
REQ-034 Boundaries:
- m=0xFFFF_FFFF, e=2, n=0xFFFF_FFFB -> r=16, latency 99 cycles.
- e=0, n=7 -> r=1 at cycle 34.
- n=1, e=5 -> r=0.
REQ-035 n=0, any m and e -> r=0, err=1, done=1 one cycle after START; a START pulse while busy leaves the result and the timing unchanged.
REQ-036 Assert RESET at cycle 100 of the m=4, e=13, n=497 run -> done stays 0 and r=0; a fresh START then yields r=445 at 229 cycles.

Source files
------------

// File: rtl/mod_exp_engine_if.sv
// mod_exp_engine_if: request/result bundle for the modular exponentiation engine.
interface mod_exp_engine_if #(parameter int BITS = 32);
   logic            start;
   logic [BITS-1:0] m;
   logic [BITS-1:0] e;
   logic [BITS-1:0] n;
   logic [BITS-1:0] r;
   logic            done;
   logic            busy;
   logic            err;
   modport master (output start, m, e, n, input r, done, busy, err);
   modport slave (input start, m, e, n, output r, done, busy, err);
endinterface

// File: rtl/mod_exp_engine.sv
// mod_exp_engine: (m^e) mod n by LSB-first square-and-multiply over a serial shift-add modmul.
module mod_exp_engine #(parameter int BITS = 32) (
   input logic             CLK,
   input logic             RESET,
   mod_exp_engine_if.slave bus
);
   localparam int W = BITS + 2;
   localparam int CW = $clog2(BITS);
   typedef enum logic [2:0] {IDLE, REDUCE, CHECK, MULT, SQUARE, DONE} state_t;
   state_t state_q, state_d;
   logic [BITS-1:0] n_q, n_d, esh_q, esh_d, base_q, base_d, acc_q, acc_d;
   logic [BITS-1:0] a_q, a_d, bsh_q, bsh_d, r_q, r_d, res;
   logic [W-1:0] p_q, p_d, nw, p2, p3, p4, step;
   logic [CW-1:0] cnt_q, cnt_d;
   logic done_q, done_d, err_q, err_d, last;
   // One interleaved modmul iteration; P stays below n, so BITS+2 bits never overflow.
   always_comb begin
      nw = {2'b00, n_q};
      p2 = p_q << 1;
      p3 = (p2 >= nw) ? p2 - nw : p2;
      p4 = p3 + (bsh_q[BITS-1] ? {2'b00, a_q} : '0);
      step = (p4 >= nw) ? p4 - nw : p4;
      res = step[BITS-1:0];
      last = cnt_q == CW'(BITS - 1);
   end
   always_comb begin
      state_d = state_q;
      n_d = n_q;
      esh_d = esh_q;
      base_d = base_q;
      acc_d = acc_q;
      a_d = a_q;
      bsh_d = bsh_q;
      p_d = p_q;
      cnt_d = cnt_q;
      r_d = r_q;
      done_d = done_q;
      err_d = err_q;
      case (state_q)
         IDLE, DONE: if (bus.start) begin
            n_d = bus.n;
            esh_d = bus.e;
            bsh_d = bus.m;
            a_d = BITS'(1);
            p_d = '0;
            cnt_d = '0;
            base_d = '0;
            acc_d = (bus.n == BITS'(1)) ? '0 : BITS'(1);
            r_d = '0;
            done_d = bus.n == '0;
            err_d = bus.n == '0;
            state_d = (bus.n == '0) ? DONE : REDUCE;
         end
         CHECK: if (esh_q == '0) begin
            r_d = acc_q;
            done_d = 1'b1;
            state_d = DONE;
         end else begin
            p_d = '0;
            cnt_d = '0;
            a_d = esh_q[0] ? acc_q : base_q;
            bsh_d = base_q;
            state_d = esh_q[0] ? MULT : SQUARE;
         end
         default: begin
            p_d = step;
            bsh_d = bsh_q << 1;
            cnt_d = cnt_q + CW'(1);
            if (last) begin
               if (state_q == REDUCE) begin
                  base_d = res;
                  state_d = CHECK;
               end else if (state_q == SQUARE) begin
                  base_d = res;
                  esh_d = esh_q >> 1;
                  state_d = CHECK;
               end else begin
                  acc_d = res;
                  // No exponent bits left above this one: the multiply just done is the last.
                  if (esh_q[BITS-1:1] == '0) begin
                     r_d = res;
                     done_d = 1'b1;
                     state_d = DONE;
                  end else begin
                     p_d = '0;
                     cnt_d = '0;
                     a_d = base_q;
                     bsh_d = base_q;
                     state_d = SQUARE;
                  end
               end
            end
         end
      endcase
   end
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q <= IDLE;
         n_q <= '0;
         esh_q <= '0;
         base_q <= '0;
         acc_q <= '0;
         a_q <= '0;
         bsh_q <= '0;
         p_q <= '0;
         cnt_q <= '0;
         r_q <= '0;
         done_q <= 1'b0;
         err_q <= 1'b0;
      end else begin
         state_q <= state_d;
         n_q <= n_d;
         esh_q <= esh_d;
         base_q <= base_d;
         acc_q <= acc_d;
         a_q <= a_d;
         bsh_q <= bsh_d;
         p_q <= p_d;
         cnt_q <= cnt_d;
         r_q <= r_d;
         done_q <= done_d;
         err_q <= err_d;
      end
   end
   assign bus.r = r_q;
   assign bus.done = done_q;
   assign bus.err = err_q;
   assign bus.busy = state_q inside {REDUCE, CHECK, MULT, SQUARE};
endmodule

// File: tb/tb_mod_exp_engine.sv
// tb_mod_exp_engine: randomized and directed runs scored against an arithmetic reference model.
module tb_mod_exp_engine;
   typedef struct {
      logic [31:0] r;
      logic        err;
      int          start;
      int          lat;
   } exp_t;
   logic CLK = 1'b0;
   logic RESET = 1'b1;
   int cyc = 0;
   int checks = 0;
   int errors = 0;
   logic done_prev = 1'b0;
   exp_t sb[$];
   exp_t mx;
   mod_exp_engine_if bus ();
   mod_exp_engine dut (.CLK(CLK), .RESET(RESET), .bus(bus));
   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask
   function automatic logic [31:0] ref_exp(input logic [31:0] m, input logic [31:0] e, input logic [31:0] n);
      logic [63:0] n64, acc, b;
      if (n == 0) return 0;
      n64 = {32'b0, n};
      acc = 64'd1 % n64;
      b = {32'b0, m} % n64;
      for (int i = 0; i < 32; i++) begin
         if (e[i]) acc = (acc * b) % n64;
         b = (b * b) % n64;
      end
      return acc[31:0];
   endfunction
   function automatic int ref_lat(input logic [31:0] e, input logic [31:0] n);
      int k;
      if (n == 0) return 1;
      if (e == 0) return 34;
      k = 0;
      for (int i = 0; i < 32; i++) if (e[i]) k = i;
      return 33 + (k + 1) + 32 * ($countones(e) + k);
   endfunction
   // Scoreboard monitor: a fresh result is a done rise, or done re-asserted by an n==0 START.
   always @(posedge CLK) begin
      #1;
      if (!RESET && bus.done && (!done_prev || bus.start)) begin
         if (sb.size() == 0) chk("unexpected_done", bus.done, 0);
         else begin
            mx = sb.pop_front();
            chk("r", bus.r, mx.r);
            chk("err", bus.err, mx.err);
            chk("latency", cyc - mx.start + 1, mx.lat);
         end
      end
      done_prev = bus.done;
   end
   task automatic run(input logic [31:0] m, input logic [31:0] e, input logic [31:0] n, input bit inj);
      int t;
      logic [31:0] x;
      x = ref_exp(m, e, n);
      @(negedge CLK);
      bus.start = 1'b1;
      bus.m = m;
      bus.e = e;
      bus.n = n;
      sb.push_back('{x, n == 0, cyc + 1, ref_lat(e, n)});
      @(negedge CLK);
      bus.start = 1'b0;
      bus.m = $urandom;
      bus.e = $urandom;
      bus.n = $urandom;
      if (n != 0) begin
         chk("busy_after_start", bus.busy, 1);
         chk("done_cleared", bus.done, 0);
         if (inj) begin
            repeat (5) @(negedge CLK);
            bus.start = 1'b1;
            @(negedge CLK);
            bus.start = 1'b0;
         end
      end
      t = 0;
      while (!bus.done && t < 4000) begin
         @(negedge CLK);
         t++;
      end
      chk("done_timeout", bus.done, 1);
      repeat (2) @(negedge CLK);
      chk("done_held", bus.done, 1);
      chk("r_held", bus.r, x);
      chk("busy_low", bus.busy, 0);
   endtask
   initial begin
      int s;
      bus.start = 1'b0;
      bus.m = '0;
      bus.e = '0;
      bus.n = '0;
      repeat (3) @(negedge CLK);
      chk("rst_r", bus.r, 0);
      chk("rst_done", bus.done, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_err", bus.err, 0);
      RESET = 1'b0;
      run(32'd4, 32'd13, 32'd497, 1);
      run(32'd65, 32'd17, 32'd3233, 0);
      run(32'd2790, 32'd2753, 32'd3233, 1);
      run(32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFB, 0);
      run(32'd123, 32'd0, 32'd7, 0);
      run(32'd9, 32'd5, 32'd1, 0);
      run(32'd0, 32'd7, 32'd11, 0);
      run(32'd55, 32'd66, 32'd0, 0);
      run(32'd0, 32'd0, 32'd0, 0);
      // Abort a run with RESET at cycle 100; no result may appear.
      @(negedge CLK);
      bus.start = 1'b1;
      bus.m = 32'd4;
      bus.e = 32'd13;
      bus.n = 32'd497;
      s = cyc + 1;
      @(negedge CLK);
      bus.start = 1'b0;
      while (cyc < s + 98) @(negedge CLK);
      RESET = 1'b1;
      bus.start = 1'b1;
      @(negedge CLK);
      RESET = 1'b0;
      bus.start = 1'b0;
      chk("abort_done", bus.done, 0);
      chk("abort_r", bus.r, 0);
      chk("abort_busy", bus.busy, 0);
      repeat (300) @(negedge CLK);
      chk("abort_no_done", bus.done, 0);
      run(32'd4, 32'd13, 32'd497, 0);
      for (int i = 0; i < 10; i++) begin
         logic [31:0] rm, re, rn;
         rm = $urandom;
         re = $urandom >> $urandom_range(0, 31);
         rn = (i % 3 == 0) ? 32'($urandom_range(1, 1000)) : $urandom;
         run(rm, re, rn, i[0]);
      end
      repeat (5) @(negedge CLK);
      chk("sb_empty", sb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
